// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle for dmem_arbiter.
// Groups the CPU request port, the DMA request port and the memory-side port.
//   slave  : the arbiter's view (requests in, grants/read data/memory drive out)
//   master : the environment's view (requesters and memory model)
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // CPU load/store path
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [1:0]        cpu_we;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  // DMA / peripheral master
  logic              dma_req;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [1:0]        dma_we;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  // Memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_lock, dma_addr, dma_wdata, dma_we,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_lock, dma_addr, dma_wdata, dma_we,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// CPU has default priority; the DMA wins after STARVE_LIMIT consecutive denied
// cycles and may hold the port for up to LOCK_MAX grants via dma_lock.
// Read data is registered per requester with a one-cycle rvalid pulse.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : dmem_arbiter_if.slave (CPU port, DMA port, memory port)
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StFree, StLocked} lock_state_e;

  lock_state_e       lock_state_q, lock_state_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic [3:0]        lock_cnt_inc;
  logic              lock_block_q, lock_block_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              lock_own;
  logic              cpu_gnt, dma_gnt;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
  logic [ADDR_W-1:0] mem_addr;

  assign lock_own     = (lock_state_q == StLocked);
  assign lock_cnt_inc = lock_cnt_q + 4'd1;

  // Grant priority: lock hold, starvation, CPU, plain DMA.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (lock_own && bus.dma_req && bus.dma_lock && !lock_block_q) begin
      dma_gnt = 1'b1;
    end else if (bus.dma_req && (starve_cnt_q == 4'(STARVE_LIMIT))) begin
      dma_gnt = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (bus.dma_req) begin
      dma_gnt = 1'b1;
    end
  end

  // With no owner the CPU address/data stay on the bus but nothing is written.
  assign mem_addr      = dma_gnt ? bus.dma_addr : bus.cpu_addr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we    = cpu_gnt ? bus.cpu_we : (dma_gnt ? bus.dma_we : 2'b00);

  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.dma_req || dma_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Lock FSM. lock_block marks the cycle after a forced exit at LOCK_MAX,
  // during which dma_lock is ignored so a waiting CPU gets through.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_cnt_d   = lock_cnt_q;
    lock_block_d = 1'b0;
    unique case (lock_state_q)
      StFree: begin
        lock_cnt_d = 4'd0;
        if (dma_gnt && bus.dma_lock && !lock_block_q) begin
          if (4'(LOCK_MAX) == 4'd1) begin
            lock_block_d = 1'b1;
          end else begin
            lock_state_d = StLocked;
            lock_cnt_d   = 4'd1;
          end
        end
      end
      StLocked: begin
        if (!bus.dma_req || !bus.dma_lock) begin
          lock_state_d = StFree;
          lock_cnt_d   = 4'd0;
        end else if (lock_cnt_inc == 4'(LOCK_MAX)) begin
          lock_state_d = StFree;
          lock_cnt_d   = 4'd0;
          lock_block_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
      default: begin
        lock_state_d = StFree;
        lock_cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we[0];
    dma_rvalid_d = dma_gnt & ~bus.dma_we[0];
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_q <= StFree;
      lock_cnt_q   <= 4'd0;
      lock_block_q <= 1'b0;
      starve_cnt_q <= 4'd0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_block_q <= lock_block_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed per-cycle grant/mux checks
// plus read-data scoreboards for both requesters.
module tb_dmem_arbiter;

  localparam int OwnNone = 0;
  localparam int OwnCpu  = 1;
  localparam int OwnDma  = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fails;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  logic [31:0] last_cpu_rd;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .LOCK_MAX(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h10) return 32'hDEAD_BEEF;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  assign bus.mem_rdata = mem_model(bus.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read-data scoreboard: each expected pulse is due exactly one cycle after its grant.
  always @(negedge clk) begin
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      check("cpu_rdata", bus.cpu_rdata, cpu_q[0].data);
      void'(cpu_q.pop_front());
    end else begin
      check("cpu_rvalid_quiet", 32'(bus.cpu_rvalid), 32'd0);
    end
    if (dma_q.size() > 0 && dma_q[0].due == cyc) begin
      check("dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
      check("dma_rdata", bus.dma_rdata, dma_q[0].data);
      void'(dma_q.pop_front());
    end else begin
      check("dma_rvalid_quiet", 32'(bus.dma_rvalid), 32'd0);
    end
  end

  // Called at posedge+1 with inputs already set; checks one cycle, returns at next posedge+1.
  task automatic step(input int own, input string tag);
    logic [31:0] ea, ew;
    logic [1:0]  ewe;
    if (own == OwnCpu && !bus.cpu_we[0]) begin
      cpu_q.push_back('{data: mem_model(bus.cpu_addr), due: cyc + 1});
      last_cpu_rd = mem_model(bus.cpu_addr);
    end
    if (own == OwnDma && !bus.dma_we[0])
      dma_q.push_back('{data: mem_model(bus.dma_addr), due: cyc + 1});
    case (own)
      OwnCpu:  begin ea = bus.cpu_addr; ew = bus.cpu_wdata; ewe = bus.cpu_we; end
      OwnDma:  begin ea = bus.dma_addr; ew = bus.dma_wdata; ewe = bus.dma_we; end
      default: begin ea = bus.cpu_addr; ew = bus.cpu_wdata; ewe = 2'b00;      end
    endcase
    @(negedge clk);
    check({tag, "_dma_gnt"}, 32'(bus.dma_gnt), 32'(own == OwnDma));
    check({tag, "_cpu_stall"}, 32'(bus.cpu_stall), 32'(bus.cpu_req && own != OwnCpu));
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(ewe));
    check({tag, "_mem_addr"}, bus.mem_addr, ea);
    check({tag, "_mem_wdata"}, bus.mem_wdata, ew);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fails = 0;
    last_cpu_rd = 32'h0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'h0; bus.cpu_we = 2'b00;
    bus.dma_req = 1'b1; bus.dma_lock = 1'b0; bus.dma_addr = 32'h200;
    bus.dma_wdata = 32'h0; bus.dma_we = 2'b00;

    // Reset with both requests active
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_dma_rdata", bus.dma_rdata, 32'd0);
    step(OwnCpu, "rst_first");

    // Idle
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h99;
    for (int i = 0; i < 3; i++) step(OwnNone, "idle");

    // CPU read
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_we = 2'b00;
    step(OwnCpu, "cpu_rd");
    bus.cpu_req = 1'b0;
    step(OwnNone, "cpu_rd_after");

    // Starvation: CPU held, DMA write waiting
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20;
    bus.dma_req = 1'b1; bus.dma_we = 2'b01; bus.dma_addr = 32'h40; bus.dma_wdata = 32'h55;
    for (int i = 0; i < 4; i++) step(OwnCpu, "starve_cpu");
    step(OwnDma, "starve_dma");
    for (int i = 0; i < 4; i++) step(OwnCpu, "starve_restart");
    step(OwnDma, "starve_dma2");
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    step(OwnNone, "starve_idle");

    // Lock limit: DMA-only reads with lock, CPU joins from the second grant
    bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_we = 2'b00; bus.dma_addr = 32'h80;
    step(OwnDma, "lock_g0");
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h24; bus.cpu_we = 2'b00;
    for (int i = 1; i < 4; i++) begin
      bus.dma_addr = 32'h80 + 32'(4 * i);
      step(OwnDma, "lock_g");
    end
    bus.dma_addr = 32'h90;
    step(OwnCpu, "lock_cpu");
    bus.cpu_req = 1'b0;
    step(OwnDma, "lock_regain");
    bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
    step(OwnNone, "lock_idle");

    // Byte store passthrough; read data must hold
    bus.cpu_req = 1'b1; bus.cpu_we = 2'b11; bus.cpu_addr = 32'h13; bus.cpu_wdata = 32'hAB;
    step(OwnCpu, "bstore");
    bus.cpu_req = 1'b0; bus.cpu_we = 2'b00;
    check("bstore_rdata_hold", bus.cpu_rdata, last_cpu_rd);
    step(OwnNone, "bstore_idle");
    check("bstore_rdata_hold2", bus.cpu_rdata, last_cpu_rd);

    step(OwnNone, "drain");
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("dma_q_drained", 32'(dma_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory access port (address, write data, 2-bit write-control, combinational read data) between the CPU load/store path and a DMA/peripheral master (loader, display fetch).
- The CPU has default priority. The DMA is protected by a starvation counter and may lock the port for short read-modify-write or burst sequences.
- Read data is registered per requester and flagged with a one-cycle valid pulse.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- STARVE_LIMIT, 4, consecutive denied DMA cycles before the DMA wins over the CPU (range 1..15).
- LOCK_MAX, 4, maximum consecutive DMA grants under lock (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_req  in  1  CPU access request, level
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_we  in  2  bit0 = write enable, bit1 = byte mode (load byte / store byte)
- cpu_stall  out  1  cpu_req high and not granted this cycle
- cpu_rdata  out  DATA_W  registered CPU read data
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
- dma_req  in  1  DMA access request, level
- dma_lock  in  1  request to keep the grant next cycle
- dma_addr  in  ADDR_W  DMA byte address
- dma_wdata  in  DATA_W  DMA store data
- dma_we  in  2  same encoding as cpu_we
- dma_gnt  out  1  DMA granted this cycle
- dma_rdata  out  DATA_W  registered DMA read data
- dma_rvalid  out  1  one-cycle pulse: dma_rdata updated
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_data
- mem_we  out  2  to memory write-control
- mem_rdata  in  DATA_W  from memory Read_data

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low. All state changes occur on the rising edge of clk.
- Reset values: starve_cnt=0, lock_cnt=0, lock_own=0, cpu_rdata=0, dma_rdata=0, cpu_rvalid=0, dma_rvalid=0.
- Reset mid-access: any pending rvalid is dropped; no pulse follows reset release.
- Grant is combinational from registered state and current requests; a granted access completes in its request cycle.
- Grant priority, evaluated in order:
  - (1) lock_own & dma_req & dma_lock → DMA.
  - (2) dma_req & starve_cnt==STARVE_LIMIT → DMA.
  - (3) cpu_req → CPU.
  - (4) dma_req → DMA.
  - (5) otherwise none.
- cpu_stall = cpu_req & ~cpu_gnt. dma_gnt is high only when the DMA owns the port.
- Memory mux:
  - Owner's address, write data and write-control drive mem_addr, mem_wdata and mem_we.
  - With no owner: mem_we=2'b00; mem_addr and mem_wdata hold the CPU values.
  - A denied requester's write never reaches memory.
- Read capture: on a granted access with we[0]=0, mem_rdata is stored into the owner's rdata register at the edge ending the grant cycle.
  - The owner's rvalid is high for exactly the next cycle.
  - Read latency is one cycle after grant.
  - Write grants produce no rvalid; rdata holds its value.
- Starvation counter (states 0..STARVE_LIMIT):
  - Increments each cycle dma_req=1 and DMA is not granted, saturating at STARVE_LIMIT.
  - Clears to 0 on a DMA grant or when dma_req=0.
- Lock FSM, states FREE and LOCKED (lock_own=1):
  - FREE→LOCKED when the DMA is granted with dma_lock=1; lock_cnt←1.
  - In LOCKED, each DMA grant with dma_lock=1 increments lock_cnt.
  - LOCKED→FREE on any of: dma_lock=0, dma_req=0, or a grant that makes lock_cnt reach LOCK_MAX.
  - After a forced exit at LOCK_MAX, dma_lock is ignored for one cycle (rule 1 disabled), so a waiting CPU wins.
  - lock_cnt clears to 0 in FREE.
- Simultaneous cpu_req and dma_req in FREE with starve_cnt<STARVE_LIMIT: CPU wins and the counter increments.
- Addresses, write data and write-control pass unmodified. Byte lane selection and byte-mode handling stay inside the memory.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles while cpu_req=1 and dma_req=1.
  - Response: all rvalid=0, rdata=0, starve_cnt=0 after release; the first cycle after release grants the CPU.
- CPU read:
  - Stimulus: cpu_req=1, cpu_addr=0x10, cpu_we=00; memory returns 0xDEADBEEF.
  - Response: cpu_stall=0; the next cycle cpu_rvalid=1 and cpu_rdata=0xDEADBEEF; dma_rvalid=0.
- Starvation:
  - Stimulus: cpu_req held high; dma_req=1 with dma_we=01, dma_addr=0x40, dma_wdata=0x55 from cycle 0.
  - Response: CPU granted cycles 0–3; cycle 4 dma_gnt=1, mem_we=01, mem_addr=0x40, cpu_stall=1; cycle 5 CPU granted again and the counter restarts.
- Lock limit:
  - Stimulus: DMA only, dma_lock=1 held, cpu_req asserted from the second DMA grant.
  - Response: exactly 4 consecutive DMA grants, then one CPU grant, then the DMA regains the port (rule 2 or 4).
- Byte store passthrough:
  - Stimulus: cpu_we=11, cpu_addr=0x13, cpu_wdata=0xAB.
  - Response: mem_we=11 and mem_addr=0x13 in the same cycle; no cpu_rvalid.
- Idle:
  - Stimulus: no requests.
  - Response: mem_we=00 every cycle; no rvalid pulses.
